// File: rtl/matmul_result_serializer.sv
// matmul_result_serializer: captures a full M x N result matrix in one
// handshake and replays it row-major as a tagged element stream.
module matmul_result_serializer #(
    parameter int M = 2,
    parameter int N = 2,
    parameter int P = 8,
    localparam int W = 4 * P,
    localparam int RW = (M > 1) ? $clog2(M) : 1,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] d_i [M][N],
    input  logic                d_valid_i,
    output logic                d_ready_o,
    output logic signed [W-1:0] out_data_o,
    output logic [RW-1:0]       out_row_o,
    output logic [CW-1:0]       out_col_o,
    output logic                out_last_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic ONE_ELEM = (M == 1) && (N == 1);

    state_t state;

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    logic signed [W-1:0] mat [M][N];

    logic          take;
    logic          step;
    logic          adv;
    logic          drain;
    logic          col_end;
    logic [RW-1:0] nrow;
    logic [CW-1:0] ncol;
    logic          nlast;

    // The slot frees on the final beat so the next matrix lands with no bubble;
    // this deliberately makes d_ready_o depend combinationally on out_ready_i.
    assign d_ready_o = (state == IDLE)
                    || (state == STREAM && out_last_o && out_ready_i);

    assign take  = d_valid_i && d_ready_o;
    assign step  = out_valid_o && out_ready_i;
    assign adv   = step && !out_last_o;
    assign drain = step && out_last_o && !d_valid_i;

    assign out_row_o = row;
    assign out_col_o = col;

    // Row-major successor of the current element index.
    always_comb begin
        col_end = (col == COL_LAST);
        ncol    = col_end ? '0 : col + CW'(1);
        nrow    = col_end ? row + RW'(1) : row;
        nlast   = (nrow == ROW_LAST) && (ncol == COL_LAST);
    end

    // Matrix holding register: written only when a new matrix is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    mat[r][c] <= '0;
                end
            end
        end else if (take) begin
            mat <= d_i;
        end
    end

    // Stream control: state, index counters and registered output fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            unique case (1'b1)
                take: begin
                    state       <= STREAM;
                    row         <= '0;
                    col         <= '0;
                    out_valid_o <= 1'b1;
                    busy_o      <= 1'b1;
                    out_data_o  <= d_i[0][0];
                    out_last_o  <= ONE_ELEM;
                end
                adv: begin
                    row        <= nrow;
                    col        <= ncol;
                    out_data_o <= mat[nrow][ncol];
                    out_last_o <= nlast;
                end
                drain: begin
                    state       <= IDLE;
                    row         <= '0;
                    col         <= '0;
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                    busy_o      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
